// File: rtl/instr_fetch_ctrl.sv
// Instruction-source front end for the 4-bit CPU.
// Owns the program counter, strobes an external synchronous ROM and hands
// each instruction to decode/execute over a valid/ready handshake.
// Sources: manual switches, free-run, single-step, or hold.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no instruction pending; waiting for a fetch or manual load
// S_FETCH | ROM read launched last cycle; rom_data is valid this cycle
// S_VALID | instr_out holds an instruction the consumer has not taken yet
module instr_fetch_ctrl #(
    parameter int IW   = 8,
    parameter int AW   = 4,
    parameter bit WRAP = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    mode,
    input  logic          pc_enable,
    input  logic          step,
    input  logic          manual_load,
    input  logic [IW-1:0] instruction,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_addr,
    input  logic [IW-1:0] rom_data,
    input  logic          instr_ready,
    output logic [AW-1:0] rom_addr,
    output logic          rom_en,
    output logic [IW-1:0] instr_out,
    output logic          instr_valid,
    output logic [AW-1:0] pc_out,
    output logic          halted
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;

    localparam logic [1:0] M_MANUAL = 2'b00;
    localparam logic [1:0] M_RUN    = 2'b01;
    localparam logic [1:0] M_STEP   = 2'b10;

    localparam logic [AW-1:0] PC_LAST = {AW{1'b1}};

    logic [1:0]    state;
    logic [AW-1:0] pc;
    logic          halted_q;
    logic          step_q;
    logic          step_edge;
    logic          go;
    logic          launch;

    // Fetch request and launch decision; a jump always wins over a launch.
    always_comb begin
        step_edge = step & ~step_q;
        go        = ~halted_q & (((mode == M_RUN) & pc_enable) |
                                 ((mode == M_STEP) & step_edge));
        launch    = 1'b0;
        if (go && !jump_en) begin
            case (state)
                S_IDLE:  launch = 1'b1;
                S_VALID: launch = instr_ready;
                default: launch = 1'b0;
            endcase
        end
    end

    // Gated by reset so the strobe drops immediately when reset asserts.
    assign rom_en   = launch & reset;
    assign rom_addr = pc;
    assign pc_out   = pc;
    assign halted   = halted_q;

    // Step history for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    // Program counter and end-of-program flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= '0;
            halted_q <= 1'b0;
        end else if (jump_en) begin
            pc       <= jump_addr;
            halted_q <= 1'b0;
        end else if (launch) begin
            pc <= pc + 1'b1;
            if ((WRAP == 1'b0) && (pc == PC_LAST)) begin
                halted_q <= 1'b1;
            end
        end
    end

    // Handshake FSM and instruction register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            instr_out   <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        state <= S_FETCH;
                    end else if ((mode == M_MANUAL) && manual_load) begin
                        instr_out   <= instruction;
                        instr_valid <= 1'b1;
                        state       <= S_VALID;
                    end
                end
                S_FETCH: begin
                    if (jump_en) begin
                        state <= S_IDLE;
                    end else begin
                        instr_out   <= rom_data;
                        instr_valid <= 1'b1;
                        state       <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= launch ? S_FETCH : S_IDLE;
                    end
                end
                default: begin
                    instr_valid <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
